// File: rtl/keypad_emulator_pkg.sv
// Shared keypad definitions: key-code layout, FSM states and the released-row value.
// The keypad scanner imports the same package so both sides agree on the key-code layout.
package keypad_pkg;

  localparam int KEY_W  = 4;
  localparam int ROW_HI = 3;
  localparam int ROW_LO = 2;
  localparam int COL_HI = 1;
  localparam int COL_LO = 0;

  localparam logic [3:0] ROW_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP
  } state_e;

  function automatic logic [1:0] key_row(input logic [KEY_W-1:0] k);
    return k[ROW_HI:ROW_LO];
  endfunction

  function automatic logic [1:0] key_col(input logic [KEY_W-1:0] k);
    return k[COL_HI:COL_LO];
  endfunction

  // Active-low row return: only the selected row line is pulled down.
  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Handshake and matrix signals between the keypad emulator and whatever drives it.
interface keypad_emulator_if;
  import keypad_pkg::*;

  logic             start;
  logic             abort;
  logic [31:0]      seq_data;
  logic [3:0]       seq_len;
  logic [3:0]       col;
  logic [3:0]       row;
  logic             busy;
  logic             done;
  logic [KEY_W-1:0] cur_key;

  modport master (
    output start, abort, seq_data, seq_len, col,
    input  row, busy, done, cur_key
  );

  modport slave (
    input  start, abort, seq_data, seq_len, col,
    output row, busy, done, cur_key
  );

endinterface

// File: rtl/keypad_emulator_cnt.sv
// Loadable down-counter that stops at zero and flags its last cycle (count of 1).
module emu_cnt #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of N therefore yields exactly N cycles before the flag is seen.
  assign tc_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/keypad_emulator.sv
// Replays a latched sequence of up to eight key closures onto an active-low 4x4 matrix,
// answering the scanner's column strobes with the matching row line.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int PRESS_CYCLES = 2_000_000,
  parameter int GAP_CYCLES   = 1_000_000,
  parameter int MAX_KEYS     = 8
) (
  input logic              clk,
  input logic              rst,
  keypad_emulator_if.slave bus
);

  localparam int CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
  localparam logic [3:0]       LEN_MAX    = 4'(MAX_KEYS);

  state_e           state_q, state_d;
  logic [31:0]      seq_q, seq_d;
  logic [3:0]       len_q, len_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       row_q, row_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [KEY_W-1:0] cur_key_q, cur_key_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;
  logic [3:0]       len_clamped;
  logic [2:0]       idx_next;
  logic             last_key;

  emu_cnt #(.WIDTH(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .tc_o       (cnt_tc)
  );

  assign len_clamped = (bus.seq_len > LEN_MAX) ? LEN_MAX : bus.seq_len;
  assign idx_next    = idx_q + 3'd1;
  assign last_key    = ({1'b0, idx_q} == (len_q - 4'd1));

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    len_d     = len_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cur_key_d = cur_key_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    row_d     = ROW_IDLE;

    // cur_key always holds the key being pressed, so it selects the column to watch.
    if (state_q == ST_PRESS && !bus.col[key_col(cur_key_q)]) begin
      row_d = row_drive(key_row(cur_key_q));
    end

    if (bus.abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      row_d   = ROW_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (len_clamped == 4'd0) begin
              done_d = 1'b1;
            end else begin
              seq_d     = bus.seq_data;
              len_d     = len_clamped;
              idx_d     = 3'd0;
              cur_key_d = bus.seq_data[KEY_W-1:0];
              cnt_load  = 1'b1;
              cnt_val   = PRESS_LOAD;
              busy_d    = 1'b1;
              state_d   = ST_PRESS;
            end
          end
        end
        ST_PRESS: begin
          if (cnt_tc) begin
            cnt_load = 1'b1;
            cnt_val  = GAP_LOAD;
            state_d  = ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_tc) begin
            if (last_key) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              idx_d     = idx_next;
              cur_key_d = seq_q[{idx_next, 2'b00} +: KEY_W];
              cnt_load  = 1'b1;
              cnt_val   = PRESS_LOAD;
              state_d   = ST_PRESS;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      seq_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      row_q     <= ROW_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cur_key_q <= '0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cur_key_q <= cur_key_d;
    end
  end

  assign bus.row     = row_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cur_key = cur_key_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomised and directed checks of keypad_emulator against a cycle-number based model
// of the key schedule (press/gap windows computed from elapsed cycles since start).
module tb_keypad_emulator;

  localparam int P = 4;
  localparam int G = 2;
  localparam int K = P + G;

  logic clk;
  logic rst;

  keypad_emulator_if bus ();

  keypad_emulator #(
    .PRESS_CYCLES (P),
    .GAP_CYCLES   (G),
    .MAX_KEYS     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Column driver: fixed pattern, one-cold rotation, or fresh random value each cycle.
  int         colMode  = 0;
  logic [3:0] colFixed = 4'hF;
  logic [1:0] rot      = 2'd0;

  always @(negedge clk) begin
    case (colMode)
      0:       bus.col = colFixed;
      1:       begin bus.col = ~(4'b0001 << rot); rot = rot + 2'd1; end
      default: bus.col = 4'($urandom);
    endcase
  end

  // Model: current busy cycle number mE (1-based) fixes key index and press/gap phase.
  logic [3:0] mSeq [8];
  int         mLen;
  int         mE;
  bit         mActive;
  bit         mDone;
  logic [3:0] mRow;
  logic [3:0] mCurKey;
  logic [3:0] mK;
  logic [3:0] mNextRow;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive = 1'b0;
      mE      = 0;
      mLen    = 0;
      mDone   = 1'b0;
      mRow    = 4'hF;
      mCurKey = 4'h0;
      for (int i = 0; i < 8; i++) mSeq[i] = 4'h0;
    end else begin
      mNextRow = 4'hF;
      if (mActive && !bus.abort && ((mE - 1) % K) < P) begin
        mK = mSeq[(mE - 1) / K];
        if (bus.col[mK[1:0]] == 1'b0) mNextRow = ~(4'b0001 << mK[3:2]);
      end
      mDone = 1'b0;
      if (bus.abort) begin
        mActive = 1'b0;
      end else if (mActive) begin
        if (mE == mLen * K) begin
          mActive = 1'b0;
          mDone   = 1'b1;
        end else begin
          mE++;
          mCurKey = mSeq[(mE - 1) / K];
        end
      end else if (bus.start) begin
        mLen = (bus.seq_len > 4'd8) ? 8 : int'(bus.seq_len);
        if (mLen == 0) begin
          mDone = 1'b1;
        end else begin
          mActive = 1'b1;
          mE      = 1;
          for (int i = 0; i < 8; i++) mSeq[i] = bus.seq_data[4*i +: 4];
          mCurKey = mSeq[0];
        end
      end
      mRow = mNextRow;
    end
  end

  always @(negedge clk) begin
    if (chkEn && !rst) begin
      checkOutput("row",     32'(bus.row),     32'(mRow));
      checkOutput("busy",    32'(bus.busy),    32'(mActive));
      checkOutput("done",    32'(bus.done),    32'(mDone));
      checkOutput("cur_key", 32'(bus.cur_key), 32'(mCurKey));
    end
  end

  // Drive the control inputs for exactly one sampled edge.
  task automatic applyStimulus(input bit st, input bit ab, input logic [31:0] d, input logic [3:0] l);
    bus.start    = st;
    bus.abort    = ab;
    bus.seq_data = d;
    bus.seq_len  = l;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic setCol(input int mode, input logic [3:0] pat);
    colMode  = mode;
    colFixed = pat;
    @(negedge clk);
  endtask

  int wBusy, wHit, wNotF, wDone, wBusyAt, wDoneAt;

  task automatic watch(input int n, input logic [3:0] hitPat);
    wBusy = 0; wHit = 0; wNotF = 0; wDone = 0; wBusyAt = -1; wDoneAt = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        wBusy++;
        if (wBusyAt < 0) wBusyAt = i;
      end
      if (bus.row == hitPat) wHit++;
      if (bus.row != 4'hF) wNotF++;
      if (bus.done) begin
        wDone++;
        if (wDoneAt < 0) wDoneAt = i;
      end
    end
  endtask

  int r;

  initial begin
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.seq_data = 32'h0;
    bus.seq_len  = 4'd0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    chkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_row",   32'(bus.row),     32'hF);
    checkOutput("reset_busy",  32'(bus.busy),    32'h0);
    checkOutput("reset_done",  32'(bus.done),    32'h0);
    checkOutput("reset_key",   32'(bus.cur_key), 32'h0);

    // Single key 6 = row 1, column 2.
    setCol(0, 4'b1011);
    applyStimulus(1'b1, 1'b0, 32'h0000_0006, 4'd1);
    watch(12, 4'b1101);
    checkOutput("single_busy",    32'(wBusy), 32'd6);
    checkOutput("single_rowlow",  32'(wHit), 32'd4);
    checkOutput("single_donegap", 32'(wDoneAt - wBusyAt), 32'd6);
    checkOutput("single_ndone",   32'(wDone), 32'd1);
    checkOutput("single_key",     32'(bus.cur_key), 32'h6);

    // Same key, wrong column strobed.
    setCol(0, 4'b1110);
    applyStimulus(1'b1, 1'b0, 32'h0000_0006, 4'd1);
    watch(12, 4'b1101);
    checkOutput("mismatch_rowact", 32'(wNotF), 32'd0);
    checkOutput("mismatch_donegap", 32'(wDoneAt - wBusyAt), 32'd6);

    // Rotating scanner: one matching strobe per four-cycle press window.
    setCol(1, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h0000_F321, 4'd4);
    watch(30, 4'hF);
    checkOutput("rot_busy",   32'(wBusy), 32'd24);
    checkOutput("rot_pulses", 32'(wNotF), 32'd4);
    checkOutput("rot_ndone",  32'(wDone), 32'd1);
    checkOutput("rot_lastkey", 32'(bus.cur_key), 32'hF);

    // Zero-length sequence.
    setCol(0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 4'd0);
    watch(4, 4'hF);
    checkOutput("len0_busy",   32'(wBusy), 32'd0);
    checkOutput("len0_doneat", 32'(wDoneAt), 32'd1);
    checkOutput("len0_ndone",  32'(wDone), 32'd1);

    // Over-length sequence clamps to eight keys.
    applyStimulus(1'b1, 1'b0, $urandom, 4'd12);
    watch(55, 4'hF);
    checkOutput("len12_busy",  32'(wBusy), 32'd48);
    checkOutput("len12_ndone", 32'(wDone), 32'd1);

    // Second start during playback must be ignored.
    setCol(2, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h0000_00A5, 4'd2);
    watch(3, 4'hF);
    applyStimulus(1'b1, 1'b0, 32'h0000_0077, 4'd1);
    watch(15, 4'hF);
    checkOutput("restart_busy",  32'(wBusy), 32'd9);
    checkOutput("restart_ndone", 32'(wDone), 32'd1);
    checkOutput("restart_key",   32'(bus.cur_key), 32'hA);

    // Abort while the second key is pressed and its column is strobed.
    setCol(0, 4'b1101);
    applyStimulus(1'b1, 1'b0, 32'h0000_0355, 4'd3);
    watch(8, 4'hF);
    checkOutput("pre_abort_row", 32'(bus.row), 32'hD);
    applyStimulus(1'b0, 1'b1, 32'h0000_0355, 4'd3);
    @(negedge clk);
    checkOutput("abort_row",  32'(bus.row),  32'hF);
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    watch(20, 4'hF);
    checkOutput("abort_ndone", 32'(wDone), 32'd0);
    checkOutput("abort_nbusy", 32'(wBusy), 32'd0);

    // Abort beats a simultaneous start.
    applyStimulus(1'b1, 1'b1, 32'h0000_0001, 4'd1);
    watch(6, 4'hF);
    checkOutput("abst_busy", 32'(wBusy), 32'd0);
    checkOutput("abst_done", 32'(wDone), 32'd0);

    // Randomised sessions, including stray starts and aborts.
    for (int it = 0; it < 40; it++) begin
      setCol($urandom_range(0, 2), 4'($urandom));
      applyStimulus(1'b1, 1'b0, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(1, 70)) begin
        @(negedge clk);
        r = $urandom_range(0, 59);
        if (r == 0)      applyStimulus(1'b0, 1'b1, $urandom, 4'($urandom));
        else if (r == 1) applyStimulus(1'b1, 1'b0, $urandom, 4'($urandom));
        else if (r == 2) applyStimulus(1'b1, 1'b1, $urandom, 4'($urandom));
      end
    end
    applyStimulus(1'b0, 1'b1, 32'h0, 4'd0);

    // Asynchronous reset in the middle of a press releases the row with no clock edge.
    setCol(0, 4'b1011);
    applyStimulus(1'b1, 1'b0, 32'h0000_0006, 4'd1);
    watch(3, 4'hF);
    checkOutput("prerst_row", 32'(bus.row), 32'hD);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_row",  32'(bus.row),  32'hF);
    checkOutput("arst_busy", 32'(bus.busy), 32'h0);
    checkOutput("arst_key",  32'(bus.cur_key), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    watch(10, 4'hF);
    checkOutput("post_rst_busy", 32'(wBusy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
